debug_run_sequencer: RTL
========================

Name: debug_run_sequencer

Overview:
Debug-side controller that sequences the MIPS PIPELINE: drives its step enable and its debug register/address selectors. It executes host commands (RUN, STEP, HALT, DUMP) and streams a full state snapshot (PC, 32 GPRs, data memory) out over a valid/ready interface. It sits between the host/UART command decoder and the PIPELINE debug ports.

Parameters:
NB, 32, data/address width
NB_SIZE_TYPE, 3, passed through to shared width constants; no local use
TAM_DATA_MEMORY, 16, number of data-memory words dumped
N_REGS, 32, number of GPRs dumped

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_cmd_valid  in  1  command strobe
i_cmd  in  2  0=RUN 1=STEP 2=HALT 3=DUMP
o_cmd_ready  out  1  command accepted this cycle when valid&ready
i_program_end  in  1  pipeline reports HALT instruction retired (level)
i_mips_pc  in  NB  pipeline PC
i_mips_register_data  in  NB  GPR selected by o_debug_mips_register_number
i_mips_data_memory  in  NB  memory word at o_debug_address
o_step  out  1  to PIPELINE i_step
o_debug_mips_register_number  out  5  GPR select
o_debug_address  out  NB  data-memory byte address
o_dump_valid  out  1  dump word available
o_dump_data  out  NB  dump word
i_dump_ready  in  1  consumer accepts dump word
o_done  out  1  sticky: program ended
o_busy  out  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE; o_step=0, selectors=0, o_dump_valid=0, o_dump_data=0, o_done=0, o_cmd_ready=1, o_busy=0.
- All outputs registered; no combinational path from inputs to outputs except o_cmd_ready (decoded from state only).
- States: IDLE, RUN, STEP, DUMP_SEL, DUMP_OUT.
- IDLE: o_cmd_ready=1. Accepted command:
  - RUN -> RUN, if o_done=0; else dropped.
  - STEP -> STEP, if o_done=0; else dropped.
  - HALT -> stays IDLE (no-op).
  - DUMP -> DUMP_SEL, index=0.
- RUN: o_step=1 every cycle. o_cmd_ready=1; only HALT acted on, others dropped. HALT or i_program_end -> IDLE; o_step=0 from the next cycle. i_program_end also sets o_done. If HALT and i_program_end occur in the same cycle: go IDLE and set o_done.
- STEP: o_step=1 for exactly one cycle, then IDLE. o_cmd_ready=0. i_program_end sampled in that cycle sets o_done.
- i_program_end seen in IDLE also sets o_done.
- Dump index: 0..(1+N_REGS+TAM_DATA_MEMORY-1) = 0..48 at defaults.
  - Index 0 = PC.
  - Index 1..32 = GPR (index-1).
  - Index 33..48 = memory byte address (index-33)*4.
- DUMP_SEL (1 cycle): drive the selector for the current index; o_dump_valid=0. Next cycle -> DUMP_OUT, capturing the selected input into o_dump_data and setting o_dump_valid=1. Select-to-capture latency is one cycle.
- DUMP_OUT: hold o_dump_data and o_dump_valid stable until i_dump_ready.
  - On handshake, if index==last -> IDLE, o_dump_valid=0.
  - Otherwise index++ -> DUMP_SEL.
  - Throughput: one word per 2 cycles at best.
- During DUMP: o_step=0 and o_cmd_ready=0; no commands accepted.
- Selectors hold their last value in IDLE/RUN/STEP. Selector fields not in use during a dump phase are 0.
- Index counter width is $clog2(1+N_REGS+TAM_DATA_MEMORY); terminal compare uses the parameter sum, with no wrap.
- o_done is cleared only by reset.

Decomposition:
- Shared package/header (debug_constants.vh): command encodings CMD_RUN/STEP/HALT/DUMP, state encodings, and dump segment bases DUMP_PC_IDX=0, DUMP_REG_BASE=1, DUMP_MEM_BASE=1+N_REGS.
- One sub-module, debug_dump_indexer: index counter plus combinational index -> (register number, address, segment select) decode. The FSM stays in the top module.

Test Plan:
- Reset mid-RUN: RUN for 5 cycles, assert i_reset -> o_step=0 immediately (async); all outputs at reset values; o_done=0.
- STEP: cmd STEP -> o_step high exactly 1 cycle; pipeline PC advances 0->4; o_cmd_ready=0 in that cycle, back to 1 after.
- RUN then HALT: RUN, HALT after 3 cycles -> exactly 3 step cycles; PC=12; o_done=0. Next STEP accepted.
- RUN to program end: i_program_end asserted at cycle 7 -> o_step low next cycle; o_done=1; subsequent RUN/STEP dropped with o_step staying 0.
- DUMP with backpressure: registers preloaded ($1=1, $7=4), i_dump_ready toggling 1-of-3 cycles -> exactly 49 words. Word0=PC, word2=1, word8=4, word33=mem[0] at address 0, word48 at address 60. o_dump_data stable while valid&!ready.
- Commands during DUMP: issue RUN mid-dump -> o_cmd_ready=0, not accepted, o_step stays 0; dump completes normally.

Source files
------------

// File: rtl/debug_run_sequencer_pkg.sv
// Shared encodings for the debug run sequencer: host commands, FSM states,
// dump segment selects and the fixed segment bases of the dump index space.
package debug_run_sequencer_pkg;

    typedef enum logic [1:0] {
        CMD_RUN  = 2'd0,
        CMD_STEP = 2'd1,
        CMD_HALT = 2'd2,
        CMD_DUMP = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_STEP     = 3'd2,
        ST_DUMP_SEL = 3'd3,
        ST_DUMP_OUT = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SEG_PC  = 2'd0,
        SEG_REG = 2'd1,
        SEG_MEM = 2'd2
    } seg_e;

    localparam int DUMP_PC_IDX   = 0;
    localparam int DUMP_REG_BASE = 1;

    // Memory words follow the PC slot and every GPR.
    function automatic int dump_mem_base(input int n_regs);
        return DUMP_REG_BASE + n_regs;
    endfunction

endpackage

// File: rtl/debug_run_sequencer_indexer.sv
// Dump index counter with decode of the next index into pipeline selectors
// and of the current index into the segment the captured word comes from.
module debug_run_sequencer_indexer
    import debug_run_sequencer_pkg::*;
#(
    parameter int NB              = 32,
    parameter int N_REGS          = 32,
    parameter int TAM_DATA_MEMORY = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [4:0]    o_nxt_reg_num,
    output logic [NB-1:0] o_nxt_addr,
    output logic [1:0]    o_cur_seg,
    output logic          o_last
);

    localparam int TOTAL    = 1 + N_REGS + TAM_DATA_MEMORY;
    localparam int IW       = $clog2(TOTAL);
    localparam int MEM_BASE = dump_mem_base(N_REGS);

    logic [IW-1:0] idx_q, idx_d;
    logic [1:0]    nxt_seg;

    function automatic logic [1:0] seg_of(input logic [IW-1:0] idx);
        if (int'(idx) >= MEM_BASE)      return SEG_MEM;
        if (int'(idx) >= DUMP_REG_BASE) return SEG_REG;
        return SEG_PC;
    endfunction

    always_comb begin
        idx_d = idx_q;
        if (i_clr)      idx_d = '0;
        else if (i_inc) idx_d = idx_q + 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) idx_q <= '0;
        else         idx_q <= idx_d;
    end

    // Selectors are registered in the top, so decode the index being loaded.
    always_comb begin
        nxt_seg       = seg_of(idx_d);
        o_nxt_reg_num = '0;
        o_nxt_addr    = '0;
        if (nxt_seg == SEG_REG)
            o_nxt_reg_num = 5'(int'(idx_d) - DUMP_REG_BASE);
        else if (nxt_seg == SEG_MEM)
            o_nxt_addr = NB'((int'(idx_d) - MEM_BASE) * 4);
    end

    assign o_cur_seg = seg_of(idx_q);
    assign o_last    = (int'(idx_q) == TOTAL - 1);

endmodule

// File: rtl/debug_run_sequencer.sv
// Debug-side controller for the MIPS pipeline: runs/steps/halts it and
// streams a PC + GPR + data-memory snapshot over a valid/ready port.
module debug_run_sequencer
    import debug_run_sequencer_pkg::*;
#(
    parameter int NB              = 32,
    parameter int NB_SIZE_TYPE    = 3,
    parameter int TAM_DATA_MEMORY = 16,
    parameter int N_REGS          = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_cmd_valid,
    input  logic [1:0]    i_cmd,
    output logic          o_cmd_ready,
    input  logic          i_program_end,
    input  logic [NB-1:0] i_mips_pc,
    input  logic [NB-1:0] i_mips_register_data,
    input  logic [NB-1:0] i_mips_data_memory,
    output logic          o_step,
    output logic [4:0]    o_debug_mips_register_number,
    output logic [NB-1:0] o_debug_address,
    output logic          o_dump_valid,
    output logic [NB-1:0] o_dump_data,
    input  logic          i_dump_ready,
    output logic          o_done,
    output logic          o_busy
);

    // Width constant shared with the rest of the debug unit; not used here.
    logic unused_size_type;
    assign unused_size_type = (NB_SIZE_TYPE != 0);

    state_e        state_q, state_d;
    logic          step_q, step_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic [NB-1:0] data_q, data_d;
    logic [4:0]    reg_q, reg_d;
    logic [NB-1:0] addr_q, addr_d;

    logic          idx_clr, idx_inc, idx_last;
    logic [4:0]    nxt_reg_num;
    logic [NB-1:0] nxt_addr;
    logic [1:0]    cur_seg;

    debug_run_sequencer_indexer #(
        .NB              (NB),
        .N_REGS          (N_REGS),
        .TAM_DATA_MEMORY (TAM_DATA_MEMORY)
    ) u_indexer (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_clr         (idx_clr),
        .i_inc         (idx_inc),
        .o_nxt_reg_num (nxt_reg_num),
        .o_nxt_addr    (nxt_addr),
        .o_cur_seg     (cur_seg),
        .o_last        (idx_last)
    );

    always_comb begin
        state_d = state_q;
        step_d  = 1'b0;
        done_d  = done_q | i_program_end;
        valid_d = valid_q;
        data_d  = data_q;
        reg_d   = reg_q;
        addr_d  = addr_q;
        idx_clr = 1'b0;
        idx_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    if (i_cmd == CMD_RUN && !done_q) begin
                        state_d = ST_RUN;
                        step_d  = 1'b1;
                    end else if (i_cmd == CMD_STEP && !done_q) begin
                        state_d = ST_STEP;
                        step_d  = 1'b1;
                    end else if (i_cmd == CMD_DUMP) begin
                        state_d = ST_DUMP_SEL;
                        idx_clr = 1'b1;
                        reg_d   = nxt_reg_num;
                        addr_d  = nxt_addr;
                    end
                end
            end
            ST_RUN: begin
                if ((i_cmd_valid && i_cmd == CMD_HALT) || i_program_end)
                    state_d = ST_IDLE;
                else
                    step_d = 1'b1;
            end
            ST_STEP: state_d = ST_IDLE;
            ST_DUMP_SEL: begin
                state_d = ST_DUMP_OUT;
                valid_d = 1'b1;
                case (cur_seg)
                    SEG_PC:  data_d = i_mips_pc;
                    SEG_REG: data_d = i_mips_register_data;
                    default: data_d = i_mips_data_memory;
                endcase
            end
            ST_DUMP_OUT: begin
                if (i_dump_ready) begin
                    valid_d = 1'b0;
                    if (idx_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DUMP_SEL;
                        idx_inc = 1'b1;
                        reg_d   = nxt_reg_num;
                        addr_d  = nxt_addr;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            reg_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            reg_q   <= reg_d;
            addr_q  <= addr_d;
        end
    end

    assign o_cmd_ready                  = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign o_step                       = step_q;
    assign o_done                       = done_q;
    assign o_busy                       = busy_q;
    assign o_dump_valid                 = valid_q;
    assign o_dump_data                  = data_q;
    assign o_debug_mips_register_number = reg_q;
    assign o_debug_address              = addr_q;

endmodule
